// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the TX arbiter FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Byte width shared by the transmitter, the receiver and the TX arbiter.
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requesting index at or after ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; found_o low when no request is set.
//
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [IW-1:0] highest-priority index (must be < N)
//   idx_o   [IW-1:0] winning index (0 when found_o is low)
//   found_o          at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // One spare bit so ptr + offset never overflows before the modulo fold.
  logic [IW:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(off);
      // Fold back explicitly so a non power-of-two N never yields index N.
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found_o && req_i[cand[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_SRC AXIS byte sources; grant held per packet or MAX_BEATS bytes.
// Latency: tvalid in IDLE -> s_tready next cycle; handshake -> tx_start next cycle; next byte 1 cycle after tx_busy falls.
// Backpressure: s_tready of the granted source only, and only while LOAD sees tx_busy low; other sources wait for IDLE.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready  per-source AXIS byte streams (source i at [i*DATA_BITS +: DATA_BITS])
//   tx_data, tx_start      byte and one-cycle start pulse to the transmitter
//   tx_busy                transmitter busy, rises the cycle after tx_start
//   grant_id, grant_active currently granted source, grant held
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC*DATA_BITS-1:0] s_tdata,
  input  logic [N_SRC-1:0]           s_tvalid,
  input  logic [N_SRC-1:0]           s_tlast,
  output logic [N_SRC-1:0]           s_tready,
  output logic [DATA_BITS-1:0]       tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       grant_active
);

  localparam int IW = $clog2(N_SRC);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [IW-1:0] LAST_SRC  = IW'(N_SRC - 1);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 last_q, last_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 sel_vld;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_dat;
  logic                 hs;

  rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req_i   (s_tvalid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Data mux for the granted source.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_dat  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == IW'(i)) begin
        sel_vld  = s_tvalid[i];
        sel_last = s_tlast[i];
        sel_dat  = s_tdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign hs = (state_q == ST_LOAD) && sel_vld && !tx_busy;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_LOAD;
      ST_LOAD:  if (hs)         state_d = ST_START;
      ST_START:                 state_d = ST_DRAIN;
      ST_DRAIN: if (!tx_busy)   state_d = last_q ? ST_IDLE : ST_LOAD;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Grant, beat counter, release flag, byte register and round-robin pointer.
  always_comb begin
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;

    if ((state_q == ST_IDLE) && pick_found) begin
      grant_d = pick_idx;
      beat_d  = '0;
    end

    if (hs) begin
      tx_data_d = sel_dat;
      // tlast and the beat limit on the same beat collapse into one release.
      last_d    = sel_last || (beat_q == LAST_BEAT);
      // Cannot pass MAX_BEATS: the limit beat always forces a release.
      beat_d    = beat_q + 1'b1;
    end

    if ((state_q == ST_DRAIN) && !tx_busy && last_q) begin
      rr_ptr_d = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      beat_q    <= '0;
      last_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      s_tready[i] = (state_q == ST_LOAD) && !tx_busy && (grant_q == IW'(i));
    end
    tx_start     = (state_q == ST_START);
    grant_active = (state_q != ST_IDLE);
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          grant_active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_SRC     (N),
    .DATA_BITS (DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  int errors;
  int checks;

  // Source byte stores: {tlast, data} per entry.
  logic [8:0] mem [N][32];
  int         wr [N];
  int         rd [N];
  logic [N-1:0] en;
  logic [N-1:0] pend;
  logic [8:0] cur;
  int         cyc;
  logic       start_seen;
  int         bcnt;
  int         onehot_bad;

  int hs_src[$];
  int hs_dat[$];
  int ts_dat[$];
  int ts_gnt[$];
  int ts_cyc[$];

  int t;
  int m;

  int exp4_src [11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};
  int exp4_dat [11] = '{'h10, 'h11, 'h12, 'h13, 'hD3, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19};

  // Transmitter model: busy for 3 cycles, starting the cycle after tx_start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (start_seen) begin
      tx_busy <= 1'b1;
      bcnt    <= 3;
    end else if (tx_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  // Source drivers and monitors, all at the falling edge.
  always @(negedge clk) begin
    cyc++;
    start_seen = tx_start && !rst;
    if (tx_start) begin
      ts_dat.push_back(int'(tx_data));
      ts_gnt.push_back(int'(grant_id));
      ts_cyc.push_back(cyc);
    end
    if ($countones(s_tready) > 1) onehot_bad++;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        cur = mem[i][rd[i] % 32];
        hs_src.push_back(i);
        hs_dat.push_back(int'(cur[7:0]));
        rd[i]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      cur = mem[i][rd[i] % 32];
      if (en[i] && (rd[i] != wr[i])) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = cur[7:0];
        s_tlast[i]          = cur[8];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
      end
      pend[i] = s_tvalid[i] && s_tready[i] && !rst;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    mem[s][wr[s] % 32] = {l, d};
    wr[s]++;
  endtask

  task automatic wait_hs(input int n, input string tag);
    int k;
    k = 0;
    while ((hs_src.size() < n) && (k < 300)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, hs_src.size() >= n, 1);
  endtask

  task automatic wait_idle(input string tag);
    int  k;
    logic done;
    k    = 0;
    done = 1'b0;
    while (!done && (k < 400)) begin
      @(negedge clk);
      #1;
      k++;
      done = !grant_active && !tx_busy && (rd[0] == wr[0]) && (rd[1] == wr[1])
             && (rd[2] == wr[2]) && (rd[3] == wr[3]);
    end
    chk(tag, done, 1);
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    onehot_bad = 0;
    start_seen = 1'b0;
    en         = '1;
    pend       = '0;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tlast    = '0;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_active", grant_active, 0);
    rst = 1'b0;
    tick();
    tick();

    // Single source: src2 sends 0x41, 0x42(last)
    t = ts_dat.size();
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    wait_idle("t1_idle");
    chk("t1_count", ts_dat.size() - t, 2);
    chk("t1_byte0", ts_dat[t], 'h41);
    chk("t1_byte1", ts_dat[t+1], 'h42);
    chk("t1_grant0", ts_gnt[t], 2);
    chk("t1_grant1", ts_gnt[t+1], 2);
    chk("t1_byte_gap", ts_cyc[t+1] - ts_cyc[t], 6);
    chk("t1_tx_data_hold", tx_data, 'h42);
    chk("t1_grant_id_hold", grant_id, 2);
    chk("t1_inactive", grant_active, 0);

    // rr_ptr is now 3: src3 beats src0
    t = ts_dat.size();
    push(0, 8'h50, 1'b1);
    push(3, 8'h53, 1'b1);
    wait_idle("t1b_idle");
    chk("t1b_first", ts_gnt[t], 3);
    chk("t1b_second", ts_gnt[t+1], 0);
    chk("t1b_pkt_gap", ts_cyc[t+1] - ts_cyc[t], 7);

    // Contention after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    t = ts_dat.size();
    for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    wait_idle("t2_idle");
    for (int i = 0; i < N; i++) chk($sformatf("t2_order%0d", i), ts_gnt[t+i], i);
    chk("t2_data3", ts_dat[t+3], 'hA3);
    chk("t2_pkt_gap", ts_cyc[t+1] - ts_cyc[t], 7);
    t = ts_dat.size();
    push(0, 8'hA4, 1'b1);
    push(1, 8'hA5, 1'b1);
    wait_idle("t2b_idle");
    chk("t2b_refill0", ts_gnt[t], 0);
    chk("t2b_refill1", ts_gnt[t+1], 1);
    chk("t2b_data0", ts_dat[t], 'hA4);

    // Packet lock: src0 arrives after src1's first byte
    m = hs_src.size();
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    wait_hs(m + 1, "t3_first_hs");
    tick();
    push(0, 8'hC0, 1'b1);
    wait_idle("t3_idle");
    chk("t3_src0", hs_src[m], 1);
    chk("t3_src1", hs_src[m+1], 1);
    chk("t3_src2", hs_src[m+2], 1);
    chk("t3_src3", hs_src[m+3], 0);
    chk("t3_last_byte", hs_dat[m+2], 'hB3);
    chk("t3_late_byte", hs_dat[m+3], 'hC0);

    // Starvation guard: src0 streams 10 bytes, src3 pending; byte 8 also carries tlast
    m = hs_src.size();
    t = ts_dat.size();
    for (int i = 0; i < 10; i++) push(0, 8'h10 + 8'(i), (i == 7) || (i == 9));
    wait_hs(m + 1, "t4_first_hs");
    tick();
    push(3, 8'hD3, 1'b1);
    wait_idle("t4_idle");
    chk("t4_count", hs_src.size() - m, 11);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t4_src%0d", i), hs_src[m+i], exp4_src[i]);
      chk($sformatf("t4_dat%0d", i), hs_dat[m+i], exp4_dat[i]);
    end
    chk("t4_gap_in_grant", ts_cyc[t+2] - ts_cyc[t+1], 6);
    chk("t4_gap_limit", ts_cyc[t+4] - ts_cyc[t+3], 7);
    chk("t4_gap_limit_tlast", ts_cyc[t+9] - ts_cyc[t+8], 7);

    // Stalled source: src2 drops tvalid after its first byte
    m = hs_src.size();
    t = ts_dat.size();
    push(2, 8'hE1, 1'b0);
    push(2, 8'hE2, 1'b0);
    push(2, 8'hE3, 1'b1);
    wait_hs(m + 1, "t5_first_hs");
    tick();
    en[2] = 1'b0;
    repeat (20) tick();
    chk("t5_no_start", ts_dat.size() - t, 1);
    chk("t5_grant_id", grant_id, 2);
    chk("t5_active", grant_active, 1);
    chk("t5_load_ready", s_tready, 4'b0100);
    en[2] = 1'b1;
    wait_idle("t5_idle");
    chk("t5_count", ts_dat.size() - t, 3);
    chk("t5_byte1", ts_dat[t+1], 'hE2);
    chk("t5_byte2", ts_dat[t+2], 'hE3);

    // Reset mid-byte
    m = hs_src.size();
    push(3, 8'h71, 1'b0);
    push(3, 8'h72, 1'b1);
    wait_hs(m + 1, "t6_first_hs");
    tick();
    chk("t6_pre_active", grant_active, 1);
    chk("t6_pre_busy", tx_busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_tx_start", tx_start, 0);
    chk("t6_tready", s_tready, 0);
    chk("t6_active", grant_active, 0);
    chk("t6_grant_id", grant_id, 0);
    chk("t6_tx_data", tx_data, 0);
    for (int i = 0; i < N; i++) wr[i] = rd[i];
    tick();
    tick();
    rst = 1'b0;
    tick();
    t = ts_dat.size();
    push(3, 8'h80, 1'b1);
    push(0, 8'h81, 1'b1);
    wait_idle("t6_idle");
    chk("t6_first_grant", ts_gnt[t], 0);
    chk("t6_second_grant", ts_gnt[t+1], 3);

    chk("ready_onehot", onehot_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among N_SRC AXI-Stream byte sources. It grants one source at a time and holds the grant for a whole packet (up to `tlast`) or until a beat limit is reached. Each accepted byte is presented to the transmitter with a one-cycle start pulse, and the arbiter waits on the transmitter's busy flag. It sits between the per-channel AXIS producers and the single serial TX line, as the counterpart of the receive path.

## Interface
- `N_SRC`, 4: number of requesting AXIS sources (2..8).
- `DATA_BITS`, 8: byte width; must match the transmitter.
- `MAX_BEATS`, 16: starvation guard; grant is released after this many bytes even without `tlast` (≥1).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `s_tdata` in N_SRC*DATA_BITS: source data; source i occupies bits [i*DATA_BITS +: DATA_BITS].
- `s_tvalid` in N_SRC: per-source valid.
- `s_tlast` in N_SRC: per-source end-of-packet.
- `s_tready` out N_SRC: per-source ready; combinational, at most one bit high.
- `tx_data` out DATA_BITS: byte to transmit; registered, stable from `tx_start` until the next handshake.
- `tx_start` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy` in 1: transmitter busy; contract is that it rises the cycle after `tx_start` and falls when the stop bit ends.
- `grant_id` out $clog2(N_SRC): currently granted source; registered.
- `grant_active` out 1: a grant is held (state ≠ IDLE).

## Operation
- FSM states: IDLE, LOAD, START, DRAIN.
- IDLE
  - If `|s_tvalid`: pick the first requesting index at or after `rr_ptr`, wrapping modulo N_SRC.
  - Register it into `grant_id`, clear `beat_cnt`, go to LOAD.
- LOAD
  - `s_tready[grant_id] = !tx_busy`.
  - On handshake (`s_tvalid[grant_id] && !tx_busy`): `tx_data <= s_tdata[grant_id]`, `tx_start <= 1`.
  - Same cycle: record `last_q = s_tlast[grant_id] || (beat_cnt == MAX_BEATS-1)`, increment `beat_cnt`, go to START.
  - If the granted source drops `tvalid`, wait in LOAD; the grant is not revoked mid-packet.
- START: `tx_start` is high this cycle only; go to DRAIN.
- DRAIN
  - Wait for `tx_busy == 0`.
  - Then if `last_q`: set `rr_ptr <= grant_id+1` (mod N_SRC) and go to IDLE.
  - Otherwise go to LOAD with the same grant.
- `beat_cnt` width is $clog2(MAX_BEATS+1) and saturates by construction; it never wraps inside a grant.
- `rr_ptr` wrap: with N_SRC not a power of two, index N_SRC-1 +1 yields 0, never N_SRC.
- `tlast` and the beat limit reached on the same beat: a single release, no extra byte.
- Requests from other sources while a grant is held are ignored until IDLE.
- Simultaneous requests in IDLE: `rr_ptr` decides. After reset `rr_ptr=0`, so source 0 wins.

## Timing
- Reset values: `s_tready=0`, `tx_start=0`, `tx_data=0`, `grant_id=0`, `grant_active=0`; internally `rr_ptr=0`, `beat_cnt=0`, state IDLE.
- Request → ready: `tvalid` seen in IDLE at cycle t gives `s_tready` at t+1, provided the transmitter is idle.
- Handshake at t → `tx_start` high at t+1 → `tx_busy` high at t+2 per the transmitter contract.
- Byte-to-byte within a packet: next `s_tready` one cycle after `tx_busy` falls.
- Packet end → next grant: IDLE for one cycle, so the new source's `s_tready` comes 2 cycles after `tx_busy` falls.
- Reset mid-operation: all outputs return to reset values asynchronously. Any byte in flight is abandoned; the transmitter is reset by the same `rst`.

## Structure
- Shared package (`uart_pkg`): `DATA_BITS` default and the FSM state encoding (2-bit enum: IDLE, LOAD, START, DRAIN).
- Sub-module `rr_pick`: combinational round-robin search taking the request vector and `rr_ptr` and returning index plus found flag. Verified stand-alone.
- Top level contains the FSM, counters and the data mux only.

## Test plan
- Single source: N_SRC=4, src2 sends 0x41,0x42 with `tlast` on 0x42. Required: two `tx_start` pulses with `tx_data` 0x41 then 0x42, `grant_id=2` throughout, then back to IDLE with `rr_ptr=3`.
- Contention after reset: all four sources valid with 1-byte packets. Required: grant order 0,1,2,3, then 0 again when refilled.
- Packet lock: src1 has a 3-byte packet, src0 asserts valid after src1's first byte. Required: all 3 src1 bytes are sent before src0's `s_tready` rises.
- Starvation guard: MAX_BEATS=4, src0 streams 10 bytes without `tlast`, src3 pending. Required: src0 sends 4 bytes, src3 is served, then src0 resumes.
- Stalled source: the granted source deasserts `tvalid` for 20 cycles mid-packet. Required: FSM holds in LOAD, no `tx_start`, grant unchanged.
- Reset mid-byte: assert `rst` during DRAIN. Required: `tx_start=0`, `s_tready=0`, `grant_active=0` immediately; first grant after release goes to source 0.
